interp_lut_pipe: RTL

- Pipelined, parametrised successor to the single-cycle combinational linear interpolator used in the activation-function path of the neural-network layers.
- Holds a writable breakpoint table and splits each input code into a table index and a fraction.
- Interpolates between adjacent entries and returns results over a valid/ready stream.
- Sits between a layer's accumulator output and the next layer's input.

---
 rtl/interp_lut_pipe.sv | 101 ++++++++++
 1 files changed

// File: rtl/interp_lut_pipe.sv
// Three-stage linear interpolator over a writable breakpoint table.
// S1 looks up the adjacent entries, S2 forms the slope product, S3 rounds and adds.
module interp_lut_pipe #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  parameter int FRAC_W = 4,
  parameter int ROUND  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tbl_we,
  input  logic [IDX_W-1:0]          tbl_addr,
  input  logic [DATA_W-1:0]         tbl_wdata,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IDX_W+FRAC_W-1:0]   in_code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data
);

  localparam int DEPTH = 2**IDX_W;
  localparam int PW    = DATA_W + FRAC_W + 2;
  localparam logic signed [PW-1:0] RND = (ROUND != 0) ? PW'(1) << (FRAC_W - 1) : PW'(0);

  function automatic logic signed [DATA_W-1:0] round_shift_add(
    input logic signed [DATA_W-1:0] b,
    input logic signed [PW-1:0]     p
  );
    logic signed [PW-1:0] t;
    t = p + RND;
    t = t >>> FRAC_W;
    t = t + PW'(b);
    return t[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] tbl [DEPTH];

  logic                     adv;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_n;
  logic [FRAC_W-1:0]        frac;
  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_x;
  logic signed [PW-1:0]     frac_x;

  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [DATA_W-1:0] base_p0, nxt_p0, base_p1, res_p2;
  logic [FRAC_W-1:0]        f_p0;
  logic signed [PW-1:0]     prod_p1;

  // Global stall: every stage moves only when the output slot is free or drained.
  assign adv       = out_ready | ~vld_p2;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign out_data  = res_p2;

  assign idx    = in_code[IDX_W+FRAC_W-1 -: IDX_W];
  assign frac   = in_code[FRAC_W-1:0];
  assign idx_n  = (idx == {IDX_W{1'b1}}) ? idx : idx + 1'b1;
  assign diff   = {nxt_p0[DATA_W-1], nxt_p0} - {base_p0[DATA_W-1], base_p0};
  assign diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
  assign frac_x = {{(PW-FRAC_W){1'b0}}, f_p0};

  // Writes land regardless of stalls; a same-edge lookup sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) tbl[k] <= '0;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      base_p0 <= '0;
      nxt_p0  <= '0;
      f_p0    <= '0;
      base_p1 <= '0;
      prod_p1 <= '0;
      res_p2  <= '0;
    end else if (adv) begin
      // S1: table lookup, last index clamps flat
      vld_p0  <= in_valid;
      base_p0 <= tbl[idx];
      nxt_p0  <= tbl[idx_n];
      f_p0    <= frac;
      // S2: slope times fraction
      vld_p1  <= vld_p0;
      base_p1 <= base_p0;
      prod_p1 <= diff_x * frac_x;
      // S3: round, shift, add to base
      vld_p2  <= vld_p1;
      res_p2  <= round_shift_add(base_p1, prod_p1);
    end
  end

endmodule
